key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 119 +++++++++++
 tb/tb_key_debounce.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Per-key synchroniser and debounce FSM for active-low board push-buttons.
// Each key yields a clean pressed level plus press, release and long-press pulses.
module key_debounce #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] h);
        return (h >= HOLD_MAX) ? h : h + HOLD_W'(1);
    endfunction

    logic [NUM_KEYS-1:0] sync_p0;
    logic [NUM_KEYS-1:0] sync_p1;
    logic [NUM_KEYS-1:0] pressed_p1;

    logic [1:0]        state [NUM_KEYS];
    logic [CNT_W-1:0]  cnt   [NUM_KEYS];
    logic [HOLD_W-1:0] hold  [NUM_KEYS];

    // Stage p0/p1: two-flop synchroniser, idles at released (1)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed_p1 = ~sync_p1;

    // Stage p2: per-key debounce FSM with registered level and pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i] <= ST_RELEASED;
                cnt[i]   <= '0;
                hold[i]  <= '0;
            end
        end else begin
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                case (state[i])
                    ST_RELEASED: begin
                        if (pressed_p1[i]) begin
                            state[i] <= ST_PRESS_DB;
                            cnt[i]   <= '0;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (!pressed_p1[i]) begin
                            state[i] <= ST_RELEASED;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]     <= ST_PRESSED;
                            key_press[i] <= 1'b1;
                            key_state[i] <= 1'b1;
                            hold[i]      <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    ST_PRESSED: begin
                        // hold stays frozen across a release bounce so key_long fires once per press
                        if (!pressed_p1[i]) begin
                            state[i] <= ST_REL_DB;
                            cnt[i]   <= '0;
                        end else begin
                            hold[i] <= hold_sat_inc(hold[i]);
                            if (hold[i] == HOLD_FIRE) begin
                                key_long[i] <= 1'b1;
                            end
                        end
                    end
                    ST_REL_DB: begin
                        if (pressed_p1[i]) begin
                            state[i] <= ST_PRESSED;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= ST_RELEASED;
                            key_release[i] <= 1'b1;
                            key_state[i]   <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: state[i] <= ST_RELEASED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16.
module tb_key_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    int total;
    int bad;

    logic [3:0] acc_press;
    logic [3:0] acc_rel;
    logic [3:0] acc_long;
    logic [3:0] acc_state;

    key_debounce #(
        .NUM_KEYS         (4),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // one active edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // advance n edges, OR-ing every pulse and level seen along the way
    task automatic run(input int n);
        acc_press = '0;
        acc_rel   = '0;
        acc_long  = '0;
        acc_state = '0;
        for (int j = 0; j < n; j++) begin
            step();
            acc_press = acc_press | key_press;
            acc_rel   = acc_rel | key_release;
            acc_long  = acc_long | key_long;
            acc_state = acc_state | key_state;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        key_n = 4'b1111;

        // reset state
        run(3);
        chk("rst_state", key_state, 4'b0000);
        chk("rst_press", key_press, 4'b0000);
        chk("rst_release", key_release, 4'b0000);
        chk("rst_long", key_long, 4'b0000);
        rst_n = 1'b1;
        run(50);
        chk("idle_pulses", acc_press | acc_rel | acc_long, 4'b0000);
        chk("idle_state", acc_state, 4'b0000);

        // key 0 press: edge k applies, pulse at k+6
        key_n[0] = 1'b0;
        run(6);
        chk("k0_press_early", acc_press, 4'b0000);
        chk("k0_state_early", acc_state, 4'b0000);
        step();
        chk("k0_press", key_press, 4'b0001);
        chk("k0_state", key_state, 4'b0001);
        step();
        chk("k0_press_width", key_press, 4'b0000);
        chk("k0_state_held", key_state, 4'b0001);

        // key 0 release
        key_n[0] = 1'b1;
        run(6);
        chk("k0_rel_early", acc_rel, 4'b0000);
        step();
        chk("k0_release", key_release, 4'b0001);
        chk("k0_state_off", key_state, 4'b0000);

        // key 1 bouncing every 2 cycles is rejected
        acc_press = '0;
        acc_state = '0;
        for (int t = 0; t < 40; t++) begin
            key_n[1] = t[1];
            step();
            acc_press = acc_press | key_press;
            acc_state = acc_state | key_state;
        end
        key_n[1] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            acc_press = acc_press | key_press;
            acc_state = acc_state | key_state;
        end
        chk("k1_bounce_press", acc_press, 4'b0000);
        chk("k1_bounce_state", acc_state, 4'b0000);

        // key 2 long press
        key_n[2] = 1'b0;
        run(6);
        chk("k2_press_early", acc_press, 4'b0000);
        step();
        chk("k2_press", key_press, 4'b0100);
        chk("k2_state", key_state, 4'b0100);
        run(15);
        chk("k2_long_early", acc_long, 4'b0000);
        step();
        chk("k2_long", key_long, 4'b0100);
        run(24);
        chk("k2_long_once", acc_long, 4'b0000);
        chk("k2_no_extra_press", acc_press, 4'b0000);
        key_n[2] = 1'b1;
        run(6);
        chk("k2_rel_early", acc_rel, 4'b0000);
        step();
        chk("k2_release", key_release, 4'b0100);
        chk("k2_state_off", key_state, 4'b0000);

        // keys 0 and 3 together, then a release glitch on key 3
        key_n = 4'b0110;
        run(6);
        chk("k03_press_early", acc_press, 4'b0000);
        step();
        chk("k03_press", key_press, 4'b1001);
        chk("k03_state", key_state, 4'b1001);
        key_n[3] = 1'b1;
        run(2);
        key_n[3] = 1'b0;
        run(6);
        chk("k3_glitch_release", acc_rel, 4'b0000);
        chk("k3_glitch_press", acc_press, 4'b0000);
        chk("k3_glitch_state", key_state, 4'b1001);
        key_n = 4'b1111;
        run(6);
        chk("k03_rel_early", acc_rel, 4'b0000);
        chk("k03_no_long", acc_long, 4'b0000);
        step();
        chk("k03_release", key_release, 4'b1001);
        chk("k03_state_off", key_state, 4'b0000);

        // reset while key 1 is mid-debounce (cnt=2), key still held afterwards
        key_n[1] = 1'b0;
        run(5);
        chk("k1_pre_rst_press", acc_press, 4'b0000);
        rst_n = 1'b0;
        run(2);
        chk("k1_rst_pulses", acc_press | acc_rel | acc_long, 4'b0000);
        chk("k1_rst_state", key_state, 4'b0000);
        rst_n = 1'b1;
        run(6);
        chk("k1_post_rst_early", acc_press, 4'b0000);
        step();
        chk("k1_post_rst_press", key_press, 4'b0010);
        chk("k1_post_rst_state", key_state, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
